// File: rtl/usb_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bridge: FSM states,
// HPI register indices and the phase-counter width.
package usb_hpi_pkg;

  localparam int HPI_CNT_W = 4;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } hpi_state_e;

  // A phase of N cycles counts N-1 down to 0, so the load value is N-1.
  function automatic logic [HPI_CNT_W-1:0] cnt_load(input int unsigned cyc);
    return HPI_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/usb_hpi_sync.sv
// Two-flop synchroniser with asynchronous active-low reset, for bringing
// asynchronous pins such as hpi_int into the clk domain.
module usb_hpi_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/usb_hpi_bridge.sv
// Avalon-MM slave that runs timed SETUP/STROBE/HOLD cycles on the CY7C67200
// HPI port and synchronises the HPI interrupt into an Avalon IRQ.
module usb_hpi_bridge
  import usb_hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        irq,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  input  logic        hpi_int
);

  localparam logic [HPI_CNT_W-1:0] SETUP_LD  = cnt_load(SETUP_CYC);
  localparam logic [HPI_CNT_W-1:0] STROBE_LD = cnt_load(STROBE_CYC);
  localparam logic [HPI_CNT_W-1:0] HOLD_LD   = cnt_load(HOLD_CYC);

  hpi_state_e           state_q, state_d;
  logic [HPI_CNT_W-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;  // 1 = write
  logic [1:0]           addr_q, addr_d;
  logic [15:0]          dout_q, dout_d;
  logic                 oe_q, oe_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rd_n_q, rd_n_d;
  logic                 wr_n_q, wr_n_d;
  logic [15:0]          rdata_q, rdata_d;

  logic req;
  logic unused_wdata_hi;

  assign req             = avs_chipselect & (avs_read | avs_write);
  assign unused_wdata_hi = ^avs_writedata[31:16];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = avs_address;
          dir_d   = avs_write;
          if (avs_write) dout_d = avs_writedata[15:0];
          cs_n_d  = 1'b0;
          oe_d    = avs_write;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          if (dir_q) wr_n_d = 1'b0;
          else       rd_n_d = 1'b0;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          // Sample the pins on the edge that ends the strobe, while rd_n is still low.
          if (!dir_q) rdata_d = hpi_data_in;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        oe_d    = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      rdata_q <= rdata_d;
    end
  end

  usb_hpi_sync #(.WIDTH(1)) u_int_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (hpi_int),
    .q     (irq)
  );

  // Valid/ready: a request completes on the edge ending the cycle where
  // req is high and waitrequest is low, which is only ever the DONE cycle.
  assign avs_waitrequest = req & (state_q != DONE);
  assign avs_readdata    = {16'b0, rdata_q};
  assign hpi_addr        = addr_q;
  assign hpi_data_out    = dout_q;
  assign hpi_data_oe     = oe_q;
  assign hpi_cs_n        = cs_n_q;
  assign hpi_rd_n        = rd_n_q;
  assign hpi_wr_n        = wr_n_q;

endmodule

// File: tb/tb_usb_hpi_bridge.sv
// Self-checking bench for usb_hpi_bridge: default-timing and 1/1/1-timing
// instances, a pin model for reads, and a scoreboard of expected read data.
module tb_usb_hpi_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_chipselect = 1'b0;
  logic        f_chipselect = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        hpi_int = 1'b0;

  logic [31:0] rdata, f_rdata;
  logic        wait_r, f_wait;
  logic        irq, f_irq;
  logic [1:0]  haddr, f_haddr;
  logic [15:0] hdout, f_hdout, hdin, f_hdin;
  logic        hoe, f_hoe, hcs_n, f_cs_n, hrd_n, f_rd_n, hwr_n, f_wr_n;

  logic [15:0] pin_word = '0;
  int          rd_age = 0;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  int          r_done, r_cs_low, r_wr_first, r_wr_last, r_wr_cnt;
  int          r_rd_first, r_rd_last, r_rd_cnt, r_oe_bad, r_addr_bad, r_data_bad;
  logic        r_cs0, r_cs_done;
  logic [31:0] r_rdata;

  always #5 clk = ~clk;

  usb_hpi_bridge dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rdata), .avs_waitrequest(wait_r),
    .irq(irq), .hpi_addr(haddr), .hpi_data_out(hdout), .hpi_data_oe(hoe),
    .hpi_data_in(hdin), .hpi_cs_n(hcs_n), .hpi_rd_n(hrd_n), .hpi_wr_n(hwr_n),
    .hpi_int(hpi_int)
  );

  usb_hpi_bridge #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_chipselect(f_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(f_rdata), .avs_waitrequest(f_wait),
    .irq(f_irq), .hpi_addr(f_haddr), .hpi_data_out(f_hdout), .hpi_data_oe(f_hoe),
    .hpi_data_in(f_hdin), .hpi_cs_n(f_cs_n), .hpi_rd_n(f_rd_n), .hpi_wr_n(f_wr_n),
    .hpi_int(hpi_int)
  );

  // Slow pin: data is valid only after rd_n has been low for two edges.
  always @(posedge clk) rd_age <= hrd_n ? 0 : rd_age + 1;
  assign hdin   = (!hrd_n && rd_age >= 2) ? pin_word : 16'h0000;
  assign f_hdin = (!f_rd_n) ? pin_word : 16'h0000;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; cycle 0 is the cycle the request is first seen.
  task automatic run_xfer(input bit sel, input logic [1:0] addr, input bit wr,
                          input logic [15:0] wdata, input bit keep_req);
    logic cs_s, rd_s, wr_s, oe_s, wt_s;
    logic [1:0]  ad_s;
    logic [15:0] do_s;
    avs_address   = addr;
    avs_write     = wr;
    avs_read      = !wr;
    avs_writedata = {16'hCAFE, wdata};
    if (sel) f_chipselect = 1'b1; else avs_chipselect = 1'b1;
    r_done = -1; r_cs_low = 0; r_wr_first = -1; r_wr_last = -1; r_wr_cnt = 0;
    r_rd_first = -1; r_rd_last = -1; r_rd_cnt = 0;
    r_oe_bad = 0; r_addr_bad = 0; r_data_bad = 0; r_cs0 = 1'bx; r_cs_done = 1'bx;
    r_rdata = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cs_s = sel ? f_cs_n : hcs_n;   rd_s = sel ? f_rd_n : hrd_n;
      wr_s = sel ? f_wr_n : hwr_n;   oe_s = sel ? f_hoe  : hoe;
      wt_s = sel ? f_wait : wait_r;  ad_s = sel ? f_haddr : haddr;
      do_s = sel ? f_hdout : hdout;
      if (k == 0) r_cs0 = cs_s;
      if (cs_s === 1'b0) begin
        r_cs_low++;
        if (oe_s !== wr) r_oe_bad++;
        if (ad_s !== addr) r_addr_bad++;
        if (wr && do_s !== wdata) r_data_bad++;
      end else if (oe_s !== 1'b0) r_oe_bad++;
      if (wr_s === 1'b0) begin
        r_wr_cnt++; r_wr_last = k; if (r_wr_first < 0) r_wr_first = k;
      end
      if (rd_s === 1'b0) begin
        r_rd_cnt++; r_rd_last = k; if (r_rd_first < 0) r_rd_first = k;
      end
      if (wt_s === 1'b0) begin
        r_done = k; r_cs_done = cs_s; r_rdata = sel ? f_rdata : rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (!keep_req) begin
      avs_chipselect = 1'b0; f_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hcs_n, hrd_n, hwr_n, hoe, haddr, hdout, rdata, irq, wait_r} !== {4'b1110, 2'b0, 16'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_dflt: got cs%b rd%b wr%b oe%b a%h d%h rdata%h irq%b wait%b, need 1 1 1 0 0 0000 00000000 0 0",
               hcs_n, hrd_n, hwr_n, hoe, haddr, hdout, rdata, irq, wait_r);
    else passed++;
    checks++;
    if ({f_cs_n, f_rd_n, f_wr_n, f_hoe, f_haddr, f_hdout, f_rdata, f_irq} !== {4'b1110, 2'b0, 16'h0, 32'h0, 1'b0})
      $display("FAIL reset_fast: got cs%b rd%b wr%b oe%b a%h d%h rdata%h irq%b, need 1 1 1 0 0 0000 00000000 0",
               f_cs_n, f_rd_n, f_wr_n, f_hoe, f_haddr, f_hdout, f_rdata, f_irq);
    else passed++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_xfer(1'b0, 2'd2, 1'b1, 16'h1234, 1'b0);
    checks++; if (r_done !== 9) $display("FAIL wr_latency: got %0d need 9", r_done); else passed++;
    checks++; if (r_cs_low !== 8) $display("FAIL wr_cs_low: got %0d need 8", r_cs_low); else passed++;
    checks++;
    if (r_wr_first !== 3 || r_wr_last !== 6 || r_wr_cnt !== 4)
      $display("FAIL wr_strobe: got first %0d last %0d cnt %0d need 3 6 4", r_wr_first, r_wr_last, r_wr_cnt);
    else passed++;
    checks++; if (r_rd_cnt !== 0) $display("FAIL wr_rd_idle: got %0d rd_n low cycles need 0", r_rd_cnt); else passed++;
    checks++;
    if (r_oe_bad !== 0 || r_addr_bad !== 0 || r_data_bad !== 0)
      $display("FAIL wr_pins: got oe_bad %0d addr_bad %0d data_bad %0d need 0 0 0", r_oe_bad, r_addr_bad, r_data_bad);
    else passed++;
    checks++; if (r_rdata !== 32'h0) $display("FAIL wr_rdata_kept: got %h need 00000000", r_rdata); else passed++;
  endtask

  task automatic test_read();
    pin_word = 16'hBEEF;
    exp_q.push_back({16'h0, 16'hBEEF});
    run_xfer(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (r_rdata !== exp_v) $display("FAIL rd_data: got %h need %h", r_rdata, exp_v); else passed++;
    checks++; if (r_done !== 9) $display("FAIL rd_latency: got %0d need 9", r_done); else passed++;
    checks++;
    if (r_oe_bad !== 0 || r_wr_cnt !== 0)
      $display("FAIL rd_oe_wr: got oe_bad %0d wr_low %0d need 0 0", r_oe_bad, r_wr_cnt);
    else passed++;
    checks++;
    if (r_rd_first !== 3 || r_rd_last !== 6 || r_addr_bad !== 0)
      $display("FAIL rd_strobe: got first %0d last %0d addr_bad %0d need 3 6 0", r_rd_first, r_rd_last, r_addr_bad);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int   done1, bad1;
    logic cs_done1;
    run_xfer(1'b0, 2'd1, 1'b1, 16'hA5A5, 1'b1);
    done1 = r_done; cs_done1 = r_cs_done; bad1 = r_addr_bad + r_data_bad + r_oe_bad;
    pin_word = 16'h5AC3;
    exp_q.push_back({16'h0, 16'h5AC3});
    run_xfer(1'b0, 2'd3, 1'b0, 16'h0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (done1 !== 9 || bad1 !== 0) $display("FAIL b2b_first: got done %0d pin_errs %0d need 9 0", done1, bad1);
    else passed++;
    checks++;
    if ({cs_done1, r_cs0} !== 2'b11) $display("FAIL b2b_gap: got cs_n %b%b across DONE/IDLE need 11", cs_done1, r_cs0);
    else passed++;
    checks++;
    if (r_addr_bad !== 0 || r_rd_cnt !== 4) $display("FAIL b2b_addr: got addr_bad %0d rd_low %0d need 0 4", r_addr_bad, r_rd_cnt);
    else passed++;
    checks++;
    if (r_done !== 9 || r_rdata !== exp_v) $display("FAIL b2b_read: got done %0d data %h need 9 %h", r_done, r_rdata, exp_v);
    else passed++;
  endtask

  task automatic test_fast_timing();
    pin_word = 16'h1357;
    exp_q.push_back({16'h0, 16'h1357});
    run_xfer(1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (r_done !== 4) $display("FAIL fast_latency: got %0d need 4", r_done); else passed++;
    checks++; if (r_rdata !== exp_v) $display("FAIL fast_data: got %h need %h", r_rdata, exp_v); else passed++;
    checks++;
    if (r_rd_first !== 2 || r_rd_cnt !== 1 || r_cs_low !== 3)
      $display("FAIL fast_strobe: got rd_first %0d rd_cnt %0d cs_low %0d need 2 1 3", r_rd_first, r_rd_cnt, r_cs_low);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    avs_address = 2'd2; avs_write = 1'b1; avs_read = 1'b0;
    avs_writedata = 32'h0000_7777; avs_chipselect = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hwr_n === 1'b0) begin seen = 1; break; end
    end
    checks++;
    if (!seen) $display("FAIL rst_mid_strobe: got no wr_n low within 20 cycles need strobe");
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hwr_n, hcs_n, hoe} !== 3'b110) $display("FAIL rst_mid_pins: got wr%b cs%b oe%b need 1 1 0", hwr_n, hcs_n, hoe);
    else passed++;
    avs_chipselect = 1'b0; avs_write = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0) $display("FAIL rst_mid_rdata: got %h need 00000000", rdata); else passed++;
    pin_word = 16'h0F0F;
    exp_q.push_back({16'h0, 16'h0F0F});
    run_xfer(1'b0, 2'd3, 1'b0, 16'h0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (r_done !== 9 || r_rdata !== exp_v || r_rd_first !== 3)
      $display("FAIL rst_fresh_read: got done %0d data %h rd_first %0d need 9 %h 3", r_done, r_rdata, r_rd_first, exp_v);
    else passed++;
  endtask

  task automatic test_irq();
    int n, m;
    checks++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b need 0", irq); else passed++;
    hpi_int = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (irq === 1'b1) break;
    end
    checks++; if (n < 2 || n > 3) $display("FAIL irq_rise: got %0d edges need 2..3", n); else passed++;
    repeat (5 - n) @(posedge clk);
    #1 hpi_int = 1'b0;
    m = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); m++;
      @(negedge clk);
      if (irq === 1'b0) break;
    end
    checks++; if (m < 2 || m > 3) $display("FAIL irq_fall: got %0d edges need 2..3", m); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_fast_timing();
    test_reset_mid();
    test_irq();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries left need 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
